// File: rtl/scan_chain_responder.sv
// Target-side scan chain endpoint: snapshots functional state, shifts it out MSB-first while
// shifting a new image in, and presents that image for restore after a complete session.
module scan_chain_responder #(
    parameter int CHAIN_LEN = 128,
    localparam int CNT_W = $clog2(CHAIN_LEN + 2)
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic                 scan_enable,
    input  logic                 scan_ck_enable,
    input  logic                 scan_input,
    output logic                 scan_output,
    input  logic [CHAIN_LEN-1:0] capture_data,
    output logic                 hold,
    output logic                 restore_valid,
    output logic [CHAIN_LEN-1:0] restore_data,
    output logic [CNT_W-1:0]     shift_count,
    output logic                 err_short,
    output logic                 err_overrun,
    input  logic                 err_clear
);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CHAIN_LEN);
    localparam logic [CNT_W-1:0] OVER_CNT = CNT_W'(CHAIN_LEN + 1);

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        SHIFT,
        UPDATE
    } state_t;

    state_t               state;
    logic [CHAIN_LEN-1:0] chain;

    // Counter parks at CHAIN_LEN+1 so an overrun stays distinguishable from a full session.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        return (cnt == OVER_CNT) ? cnt : cnt + 1'b1;
    endfunction

    assign scan_output = chain[CHAIN_LEN-1];

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state         <= IDLE;
            chain         <= '0;
            restore_data  <= '0;
            shift_count   <= '0;
            hold          <= 1'b0;
            restore_valid <= 1'b0;
            err_short     <= 1'b0;
            err_overrun   <= 1'b0;
        end else begin
            restore_valid <= 1'b0;
            // Error sets below are later assignments, so they win over a same-cycle clear.
            if (err_clear) begin
                err_short   <= 1'b0;
                err_overrun <= 1'b0;
            end

            case (state)
                IDLE: begin
                    hold <= 1'b0;
                    if (scan_enable) begin
                        state <= CAPTURE;
                    end
                end

                CAPTURE: begin
                    chain       <= capture_data;
                    shift_count <= '0;
                    hold        <= 1'b1;
                    state       <= SHIFT;
                end

                SHIFT: begin
                    if (!scan_enable) begin
                        state <= UPDATE;
                    end else if (scan_ck_enable) begin
                        chain       <= {chain[CHAIN_LEN-2:0], scan_input};
                        shift_count <= sat_inc(shift_count);
                        if (shift_count == FULL_CNT) begin
                            err_overrun <= 1'b1;
                        end
                    end
                end

                UPDATE: begin
                    hold  <= 1'b0;
                    state <= IDLE;
                    if (shift_count == FULL_CNT) begin
                        restore_data  <= chain;
                        restore_valid <= 1'b1;
                    end else if (shift_count < FULL_CNT) begin
                        err_short <= 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_scan_chain_responder.sv
// Scoreboard bench for scan_chain_responder: an 8-bit chain for session scenarios and a 128-bit chain
// for the long-pattern session.
module tb_scan_chain_responder;

    localparam int N  = 8;
    localparam int NB = 128;

    logic clk = 1'b0;
    logic aresetn = 1'b0;

    logic          scan_enable = 1'b0;
    logic          scan_ck_enable = 1'b0;
    logic          scan_input = 1'b0;
    logic          err_clear = 1'b0;
    logic [N-1:0]  capture_data = '0;
    logic          scan_output, hold, restore_valid, err_short, err_overrun;
    logic [N-1:0]  restore_data;
    logic [3:0]    shift_count;

    logic          b_scan_enable = 1'b0;
    logic          b_scan_ck_enable = 1'b0;
    logic          b_scan_input = 1'b0;
    logic          b_err_clear = 1'b0;
    logic [NB-1:0] b_capture_data = '0;
    logic          b_scan_output, b_hold, b_restore_valid, b_err_short, b_err_overrun;
    logic [NB-1:0] b_restore_data;
    logic [7:0]    b_shift_count;

    int checks = 0;
    int errors = 0;

    bit            exp_out_q[$];
    logic [N-1:0]  exp_rst_q[$];
    logic [NB-1:0] b_exp_rst_q[$];
    logic [N-1:0]  last_restore = '0;

    scan_chain_responder #(.CHAIN_LEN(N)) dut (
        .aclk(clk), .aresetn(aresetn), .scan_enable(scan_enable), .scan_ck_enable(scan_ck_enable),
        .scan_input(scan_input), .scan_output(scan_output), .capture_data(capture_data), .hold(hold),
        .restore_valid(restore_valid), .restore_data(restore_data), .shift_count(shift_count),
        .err_short(err_short), .err_overrun(err_overrun), .err_clear(err_clear)
    );

    scan_chain_responder #(.CHAIN_LEN(NB)) dut_long (
        .aclk(clk), .aresetn(aresetn), .scan_enable(b_scan_enable), .scan_ck_enable(b_scan_ck_enable),
        .scan_input(b_scan_input), .scan_output(b_scan_output), .capture_data(b_capture_data),
        .hold(b_hold), .restore_valid(b_restore_valid), .restore_data(b_restore_data),
        .shift_count(b_shift_count), .err_short(b_err_short), .err_overrun(b_err_overrun),
        .err_clear(b_err_clear)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One session on the 8-bit chain: n strobes with bits din[0..n-1]; optional random gaps
    // plus strobes in the CAPTURE cycle and the scan_enable-falling cycle.
    task automatic session8(input string name, input logic [7:0] cap, input int n,
                            input logic [15:0] din, input bit gapped);
        logic [7:0] exp_r;
        logic [7:0] er;
        bit         eb;
        int         exp_cnt;
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        exp_r = '0;
        for (int i = 0; i < n; i++) begin
            exp_out_q.push_back(i < 8 ? cap[7-i] : din[i-8]);
            if (i < 8) exp_r[7-i] = din[i];
        end
        if (n == 8) exp_rst_q.push_back(exp_r);

        capture_data = cap;
        scan_enable  = 1'b1;
        tick();
        if (gapped) begin
            scan_ck_enable = 1'b1;
            scan_input     = ~din[0];
        end
        tick();
        scan_ck_enable = 1'b0;
        checks++;
        if (hold !== 1'b1) begin errors++; $display("FAIL %s hold_shift: got %b want 1", name, hold); end

        for (int i = 0; i < n; i++) begin
            if (gapped) repeat ($urandom_range(0, 3)) tick();
            eb = exp_out_q.pop_front();
            checks++;
            if (scan_output !== eb) begin
                errors++;
                $display("FAIL %s scan_output[%0d]: got %b want %b", name, i, scan_output, eb);
            end
            scan_input     = din[i];
            scan_ck_enable = 1'b1;
            tick();
            scan_ck_enable = 1'b0;
            checks++;
            if (err_overrun !== (i >= 8)) begin
                errors++;
                $display("FAIL %s err_overrun_step[%0d]: got %b want %b", name, i, err_overrun, (i >= 8));
            end
        end

        scan_enable = 1'b0;
        if (gapped) begin
            scan_ck_enable = 1'b1;
            scan_input     = 1'b1;
        end
        tick();
        scan_ck_enable = 1'b0;
        checks++;
        if (hold !== 1'b1 || restore_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s update_cycle: got hold=%b valid=%b want hold=1 valid=0", name, hold, restore_valid);
        end

        tick();
        er = (n == 8) ? exp_rst_q.pop_front() : last_restore;
        exp_cnt = (n > 9) ? 9 : n;
        checks++;
        if (restore_valid !== (n == 8)) begin
            errors++;
            $display("FAIL %s restore_valid: got %b want %b", name, restore_valid, (n == 8));
        end
        checks++;
        if (restore_data !== er) begin
            errors++;
            $display("FAIL %s restore_data: got %h want %h", name, restore_data, er);
        end
        checks++;
        if (shift_count !== 4'(exp_cnt)) begin
            errors++;
            $display("FAIL %s shift_count: got %0d want %0d", name, shift_count, exp_cnt);
        end
        checks++;
        if (err_short !== (n < 8)) begin
            errors++;
            $display("FAIL %s err_short: got %b want %b", name, err_short, (n < 8));
        end
        checks++;
        if (err_overrun !== (n > 8)) begin
            errors++;
            $display("FAIL %s err_overrun: got %b want %b", name, err_overrun, (n > 8));
        end
        checks++;
        if (hold !== 1'b0) begin errors++; $display("FAIL %s hold_release: got %b want 0", name, hold); end
        if (n == 8) last_restore = er;

        tick();
        checks++;
        if (restore_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s restore_valid_pulse: got %b want 0", name, restore_valid);
        end
    endtask

    task automatic test_reset();
        aresetn     = 1'b0;
        scan_enable = 1'b1;
        capture_data = 8'h80;
        repeat (5) tick();
        checks++;
        if ({scan_output, hold, restore_valid, err_short, err_overrun} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b want 00000",
                     {scan_output, hold, restore_valid, err_short, err_overrun});
        end
        checks++;
        if (restore_data !== 8'h00 || shift_count !== 4'd0) begin
            errors++;
            $display("FAIL reset_data: got data=%h cnt=%0d want 00/0", restore_data, shift_count);
        end
        aresetn = 1'b1;
        tick();
        checks++;
        if (hold !== 1'b0) begin errors++; $display("FAIL reset_idle_exit: got hold=%b want 0", hold); end
        tick();
        checks++;
        if (hold !== 1'b1 || shift_count !== 4'd0 || scan_output !== 1'b1) begin
            errors++;
            $display("FAIL reset_capture: got hold=%b cnt=%0d out=%b want 1/0/1", hold, shift_count, scan_output);
        end
        // Empty session: scan_enable dropped right after capture.
        scan_enable = 1'b0;
        tick();
        tick();
        checks++;
        if (restore_valid !== 1'b0 || err_short !== 1'b1) begin
            errors++;
            $display("FAIL empty_session: got valid=%b short=%b want 0/1", restore_valid, err_short);
        end
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        checks++;
        if (err_short !== 1'b0) begin errors++; $display("FAIL empty_clear: got %b want 0", err_short); end
    endtask

    task automatic test_full();
        session8("full", 8'hA5, 8, 16'h0053, 1'b0);
        checks++;
        if (restore_data !== 8'hCA) begin errors++; $display("FAIL full_image: got %h want ca", restore_data); end
    endtask

    task automatic test_short();
        session8("short", 8'h3C, 5, 16'h001F, 1'b0);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        checks++;
        if (err_short !== 1'b0) begin errors++; $display("FAIL short_clear: got %b want 0", err_short); end
    endtask

    task automatic test_overrun();
        session8("overrun", 8'h5A, 10, 16'h02B6, 1'b0);
    endtask

    task automatic test_gapped();
        session8("gapped", 8'hA5, 8, 16'h0053, 1'b1);
        checks++;
        if (restore_data !== 8'hCA) begin errors++; $display("FAIL gapped_image: got %h want ca", restore_data); end
    endtask

    task automatic test_reset_mid();
        capture_data = 8'hF0;
        scan_enable  = 1'b1;
        tick();
        tick();
        repeat (4) begin
            scan_input     = 1'b1;
            scan_ck_enable = 1'b1;
            tick();
        end
        scan_ck_enable = 1'b0;
        aresetn = 1'b0;
        tick();
        aresetn     = 1'b1;
        scan_enable = 1'b0;
        last_restore = '0;
        checks++;
        if ({hold, err_short, err_overrun} !== 3'b0 || shift_count !== 4'd0 || restore_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_mid_state: got hold=%b short=%b over=%b cnt=%0d data=%h want all 0",
                     hold, err_short, err_overrun, shift_count, restore_data);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (restore_valid !== 1'b0 || err_short !== 1'b0 || err_overrun !== 1'b0) begin
                errors++;
                $display("FAIL reset_mid_after[%0d]: got valid=%b short=%b over=%b want 0",
                         i, restore_valid, err_short, err_overrun);
            end
        end
    endtask

    task automatic test_long();
        logic [NB-1:0] pat;
        logic [NB-1:0] cap;
        logic [NB-1:0] er;
        bit            eb;
        pat = {4{32'hAAAAAAAF}};
        cap = {32'h01234567, 32'h89ABCDEF, 32'hFEDCBA98, 32'h76543210};
        for (int i = 0; i < NB; i++) exp_out_q.push_back(cap[NB-1-i]);
        b_exp_rst_q.push_back(pat);
        b_capture_data = cap;
        b_scan_enable  = 1'b1;
        tick();
        tick();
        for (int i = 0; i < NB; i++) begin
            eb = exp_out_q.pop_front();
            checks++;
            if (b_scan_output !== eb) begin
                errors++;
                $display("FAIL long scan_output[%0d]: got %b want %b", i, b_scan_output, eb);
            end
            b_scan_input     = pat[NB-1-i];
            b_scan_ck_enable = 1'b1;
            tick();
        end
        b_scan_ck_enable = 1'b0;
        b_scan_enable    = 1'b0;
        tick();
        tick();
        er = b_exp_rst_q.pop_front();
        checks++;
        if (b_restore_valid !== 1'b1 || b_restore_data !== er) begin
            errors++;
            $display("FAIL long_restore: got valid=%b data=%h want 1/%h", b_restore_valid, b_restore_data, er);
        end
        checks++;
        if (b_shift_count !== 8'd128 || b_err_short !== 1'b0 || b_err_overrun !== 1'b0 || b_hold !== 1'b0) begin
            errors++;
            $display("FAIL long_status: got cnt=%0d short=%b over=%b hold=%b want 128/0/0/0",
                     b_shift_count, b_err_short, b_err_overrun, b_hold);
        end
        tick();
        checks++;
        if (b_restore_valid !== 1'b0) begin errors++; $display("FAIL long_pulse: got %b want 0", b_restore_valid); end
    endtask

    initial begin
        test_reset();
        test_full();
        test_short();
        test_overrun();
        test_gapped();
        test_reset_mid();
        test_long();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
